// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU operation sequencer.
// Opcodes, decode masks, ALU codes and FSM states.
package alu_seq_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_ADD64 = 3'b110;
  localparam logic [2:0] OP_SUB64 = 3'b111;

  // Decode masks indexed by req_op
  localparam logic [7:0] LEGAL  = 8'b1100_1111;
  localparam logic [7:0] IS64   = 8'b1100_0000;
  localparam logic [7:0] IS_SUB = 8'b1000_1000;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_FIX  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  function automatic logic [1:0] alu_code(
    input logic [1:0] op
  );
    logic [1:0] c;
    c = ALU_ADD;
    if (op == 2'b00) c = ALU_AND;
    if (op == 2'b01) c = ALU_OR;
    return c;
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequences 32/64-bit ALU requests over a 32-bit combinational ALU.
// 64-bit ADD/SUB take a low pass, a high pass, and an optional carry fix.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_binvert,
  output logic        alu_carryin,
  output logic [1:0]  alu_operation,
  input  logic [31:0] alu_result,
  input  logic        alu_carryout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic        rsp_err
);

  state_t      state;
  logic [2:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic [31:0] res_lo;
  logic        c_lo;
  logic        c_hi;

  assign alu_carryin = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      op            <= 3'b000;
      a             <= 64'h0;
      b             <= 64'h0;
      res_lo        <= 32'h0;
      c_lo          <= 1'b0;
      c_hi          <= 1'b0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_result    <= 64'h0;
      rsp_carry     <= 1'b0;
      rsp_zero      <= 1'b0;
      rsp_err       <= 1'b0;
      alu_a         <= 32'h0;
      alu_b         <= 32'h0;
      alu_binvert   <= 1'b0;
      alu_operation <= ALU_AND;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            op        <= req_op;
            a         <= req_a;
            b         <= req_b;
            req_ready <= 1'b0;
            if (!LEGAL[req_op]) begin
              state      <= S_RESP;
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_result <= 64'h0;
              rsp_carry  <= 1'b0;
              rsp_zero   <= 1'b1;
            end else begin
              state         <= S_LO;
              rsp_err       <= 1'b0;
              alu_a         <= req_a[31:0];
              alu_b         <= req_b[31:0];
              alu_binvert   <= IS_SUB[req_op];
              alu_operation <= alu_code(req_op[1:0]);
            end
          end
        end
        S_LO: begin
          res_lo <= alu_result;
          c_lo   <= alu_carryout;
          if (IS64[op]) begin
            state <= S_HI;
            alu_a <= a[63:32];
            alu_b <= b[63:32];
          end else begin
            state      <= S_RESP;
            rsp_valid  <= 1'b1;
            rsp_result <= {32'h0, alu_result};
            rsp_zero   <= (alu_result == 32'h0);
            rsp_carry  <= (alu_operation == ALU_ADD) & alu_carryout;
          end
        end
        S_HI: begin
          c_hi <= alu_carryout;
          // High pass used carry-in = binvert; correct it when c_lo differs
          if (c_lo == alu_binvert) begin
            state      <= S_RESP;
            rsp_valid  <= 1'b1;
            rsp_result <= {alu_result, res_lo};
            rsp_zero   <= ({alu_result, res_lo} == 64'h0);
            rsp_carry  <= alu_carryout;
          end else begin
            state       <= S_FIX;
            alu_a       <= alu_result;
            alu_b       <= IS_SUB[op] ? 32'hFFFF_FFFF : 32'h1;
            alu_binvert <= 1'b0;
          end
        end
        S_FIX: begin
          state      <= S_RESP;
          rsp_valid  <= 1'b1;
          rsp_result <= {alu_result, res_lo};
          rsp_zero   <= ({alu_result, res_lo} == 64'h0);
          rsp_carry  <= IS_SUB[op] ? (c_hi & alu_carryout)
                                   : (c_hi | alu_carryout);
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer with a behavioural 32-bit ALU responder.
// Directed table, corner sequences, and randomized ops against a model.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_binvert;
  logic        alu_carryin;
  logic [1:0]  alu_operation;
  logic [31:0] alu_result;
  logic        alu_carryout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        rsp_err;

  int checks;
  int errors;

  alu_op_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_binvert  (alu_binvert),
    .alu_carryin  (alu_carryin),
    .alu_operation(alu_operation),
    .alu_result   (alu_result),
    .alu_carryout (alu_carryout),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_zero     (rsp_zero),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: carry-in is the binvert bit; alu_carryin ignored
  logic [31:0] bb;
  logic [32:0] sum;
  always_comb begin
    bb = alu_binvert ? ~alu_b : alu_b;
    sum = {1'b0, alu_a} + {1'b0, bb} + {32'h0, alu_binvert};
    alu_carryout = sum[32];
    alu_result = sum[31:0];
    if (alu_operation == 2'b00) alu_result = alu_a & bb;
    if (alu_operation == 2'b01) alu_result = alu_a | bb;
  end

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        c;
    logic        z;
    logic        e;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Reference computed from arithmetic on the full operands
  task automatic model(input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, output vec_t v);
    logic [64:0] s;
    logic [32:0] s32;
    v.op = op; v.a = a; v.b = b;
    v.c = 1'b0; v.e = 1'b0; v.lat = 2; v.res = 64'h0;
    s32 = {1'b0, a[31:0]} + {1'b0, b[31:0]};
    case (op)
      3'b000: v.res = {32'h0, a[31:0] & b[31:0]};
      3'b001: v.res = {32'h0, a[31:0] | b[31:0]};
      3'b010: begin
        v.res = {32'h0, s32[31:0]};
        v.c = s32[32];
      end
      3'b011: begin
        v.res = {32'h0, a[31:0] - b[31:0]};
        v.c = (a[31:0] >= b[31:0]);
      end
      3'b110: begin
        s = {1'b0, a} + {1'b0, b};
        v.res = s[63:0];
        v.c = s[64];
        v.lat = s32[32] ? 4 : 3;
      end
      3'b111: begin
        v.res = a - b;
        v.c = (a >= b);
        v.lat = (a[31:0] < b[31:0]) ? 4 : 3;
      end
      default: begin
        v.e = 1'b1;
        v.lat = 1;
      end
    endcase
    v.z = (v.res == 64'h0);
  endtask

  task automatic do_op(input vec_t v, input int hold, input string tag);
    int lat;
    logic [63:0] r0;
    @(negedge clk);
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
    chk({tag, ".req_ready"}, {63'h0, req_ready}, 64'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      errors++; checks++;
      $display("FAIL %s.timeout got=no rsp want=rsp", tag);
      return;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(v.lat));
    chk({tag, ".res"}, rsp_result, v.res);
    chk({tag, ".flags"}, {61'h0, rsp_carry, rsp_zero, rsp_err},
        {61'h0, v.c, v.z, v.e});
    r0 = rsp_result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold"}, {rsp_result, 62'h0, rsp_valid, req_ready},
          {r0, 62'h0, 1'b1, 1'b0});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".done"}, {62'h0, rsp_valid, req_ready}, 64'h1);
  endtask

  vec_t tbl[7];
  vec_t rv;
  logic [63:0] ra;
  logic [63:0] rb;
  logic [2:0]  rop;

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; req_valid = 1'b0; req_op = 3'b000;
    req_a = 64'h0; req_b = 64'h0; rsp_ready = 1'b0;

    tbl[0] = '{OP_AND, 64'hA5A5A5A5, 64'h5A5A5A5A, 64'h0, 1'b0, 1'b1, 1'b0, 2};
    tbl[1] = '{OP_ADD64, 64'h0000_0000_FFFF_FFFF, 64'h1,
               64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 4};
    tbl[2] = '{OP_SUB64, 64'h0000_0001_0000_0000, 64'h1,
               64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 4};
    tbl[3] = '{OP_SUB64, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
               64'h0, 1'b1, 1'b1, 1'b0, 3};
    tbl[4] = '{OP_OR, 64'hFFFF_0000_0000_00F0, 64'h0F,
               64'hFF, 1'b0, 1'b0, 1'b0, 2};
    tbl[5] = '{OP_SUB, 64'h3, 64'h5, 64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 2};
    tbl[6] = '{3'b101, 64'h7, 64'h7, 64'h0, 1'b0, 1'b1, 1'b1, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.out", {rsp_result, 1'b0, rsp_valid, req_ready, rsp_carry,
                      rsp_zero, rsp_err, alu_binvert, alu_carryin},
        {64'h0, 8'b0010_0000});
    chk("reset.alu", {alu_a, alu_b}, 64'h0);
    reset = 1'b0;

    foreach (tbl[i]) do_op(tbl[i], 0, $sformatf("tbl%0d", i));

    rv = '{OP_ADD, 64'h7, 64'h9, 64'd16, 1'b0, 1'b0, 1'b0, 2};
    do_op(rv, 5, "hold");
    rv = '{3'b100, 64'h1, 64'h2, 64'h0, 1'b0, 1'b1, 1'b1, 1};
    do_op(rv, 0, "illegal");

    // Reset while the high pass of an ADD64 is on the ALU
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_ADD64;
    req_a = 64'h0000_0005_FFFF_FFFF; req_b = 64'h1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort.state", {62'h0, rsp_valid, req_ready}, 64'h1);
    chk("abort.alu", {alu_a, alu_b}, 64'h0);
    repeat (3) @(negedge clk);
    chk("abort.norsp", {63'h0, rsp_valid}, 64'h0);
    rv = '{OP_ADD, 64'h1, 64'h1, 64'h2, 1'b0, 1'b0, 1'b0, 2};
    do_op(rv, 0, "after_abort");

    for (int n = 0; n < 60; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: ;
        1: rb = ra;
        2: begin ra[31:0] = 32'hFFFF_FFFF; rb[31:0] = 32'h1; end
        default: begin ra = 64'($urandom_range(0, 3)); rb = 64'($urandom_range(0, 3)); end
      endcase
      rop = 3'($urandom_range(0, 7));
      model(rop, ra, rb, rv);
      do_op(rv, $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
